mux3: RTL and testbench
=======================

MUX3 -- requirements
Module: mux3

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits for all data inputs and outputs.
REQ-002 clk  input  1  single clock; all sequential state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 sel  input  2  source select: 00 selects data_in1, 01 selects data_in2, 10 selects data_in3, 11 is invalid.
REQ-005 data_in1  input  WIDTH  source 1.
REQ-006 data_in2  input  WIDTH  source 2.
REQ-007 data_in3  input  WIDTH  source 3.
REQ-008 en  input  1  load enable for the registered output.
REQ-009 clr  input  1  synchronous clear of the sticky error flag.
REQ-010 data_out  output  WIDTH  combinational selected data.
REQ-011 data_out_q  output  WIDTH  registered copy of data_out.
REQ-012 sel_err  output  1  combinational invalid-select indicator.
REQ-013 sel_err_sticky  output  1  registered, sticky invalid-select flag.

Function
REQ-014 data_out SHALL equal data_in1 when sel=00, data_in2 when sel=01, and data_in3 when sel=10.
REQ-015 data_out SHALL be all zeros when sel=11.
REQ-016 data_out SHALL be purely combinational: zero latency, and independent of clk, rst, en and clr.
REQ-017 sel_err SHALL be 1 exactly when sel=11, combinationally, and 0 otherwise.
REQ-018 On a rising clk edge with rst=0 and en=1, data_out_q SHALL load the current value of data_out; with en=0, data_out_q SHALL hold its value.
REQ-019 data_out_q SHALL reflect a sel or data change on the first rising edge after the change, i.e. one cycle of latency.
REQ-020 On a rising clk edge with rst=0, sel_err_sticky SHALL be set to 1 when sel=11, regardless of en.
REQ-021 Once set, sel_err_sticky SHALL remain 1 until cleared by clr or rst.
REQ-022 On a rising clk edge with clr=1, sel_err_sticky SHALL be cleared to 0.
REQ-023 clr SHALL take priority over a simultaneous set, so that clr=1 with sel=11 yields 0.
REQ-024 clr SHALL NOT affect data_out_q.
REQ-025 All arithmetic SHALL be pure selection with no width conversion: every data input and output is exactly WIDTH bits.
REQ-026 With WIDTH changed, behaviour SHALL be identical bitwise across the full width.

Reset
REQ-027 When rst=1, data_out_q SHALL become 0 and sel_err_sticky SHALL become 0 immediately, without waiting for a clk edge.
REQ-028 While rst=1, data_out_q and sel_err_sticky SHALL hold 0 regardless of clk, en and clr.
REQ-029 Reset asserted mid-operation SHALL override any pending load or set.
REQ-030 The first rising edge after rst deasserts SHALL resume normal loading.
REQ-031 data_out and sel_err SHALL remain valid combinational functions of sel and the data inputs during reset.

Verification
REQ-032 in1=0x00000001, in2=0x00000002, in3=0x00000003, stepping sel through 00, 01, 10, 11 every 10 time units -> data_out follows 1, 2, 3, then 0, and sel_err is 1 only while sel=11.
REQ-033 en=1 with sel stepped 00 -> 01 on clk edges -> data_out_q = 0x00000001, then 0x00000002 one cycle after the step.
REQ-034 data_out_q=0x2 with en=0, then sel changed to 10 -> data_out = 0x3 immediately while data_out_q stays 0x2 until en=1 and a clk edge.
REQ-035 sel=11 for one cycle, then sel=00 -> sel_err_sticky = 1 and stays 1; clr=1 for one edge -> sticky = 0; clr=1 with sel=11 on the same edge -> sticky = 0.
REQ-036 data_out_q=0x3 and sticky=1, then rst pulsed between clk edges -> both outputs read 0 before the next edge, while data_out still shows the selected input.
REQ-037 WIDTH=8 instance with inputs 0xFF, 0xA5, 0x5A -> correct selection on all 8 bits and zero output on sel=11.

Source files
------------

// File: rtl/mux3.sv
// Three-way data selector with a registered, load-enabled copy of the selection
// and a sticky flag that records any use of the invalid select code.
module mux3 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_out_q,
    output logic             sel_err,
    output logic             sel_err_sticky
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             sticky_d;
    logic             sticky_q;

    // Invalid select (2'b11) drives zeros so nothing stale leaks downstream.
    always_comb begin
        data_out = '0;
        case (sel)
            2'b00:   data_out = data_in1;
            2'b01:   data_out = data_in2;
            2'b10:   data_out = data_in3;
            default: data_out = '0;
        endcase
    end

    assign sel_err = (sel == 2'b11);

    // clr wins over a same-edge set so software can always acknowledge the flag.
    always_comb begin
        data_d   = en ? data_out : data_q;
        sticky_d = sticky_q;
        if (clr) begin
            sticky_d = 1'b0;
        end else if (sel_err) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            sticky_q <= sticky_d;
        end
    end

    assign data_out_q     = data_q;
    assign sel_err_sticky = sticky_q;

endmodule

// File: tb/tb_mux3.sv
// Self-checking bench for mux3: directed scenarios plus randomized traffic on a
// 32-bit and an 8-bit instance, checked against a behavioural model.
module tb_mux3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'b00;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, c32 = '0;
    logic [7:0]  a8  = '0, b8  = '0, c8  = '0;

    logic [31:0] out32, out32_q;
    logic        err32, sticky32;
    logic [7:0]  out8, out8_q;
    logic        err8, sticky8;

    int ntests = 0;
    int nfail  = 0;

    // Model state
    logic [31:0] m_q32 = '0;
    logic [7:0]  m_q8  = '0;
    logic        m_st  = 1'b0;

    always #5 clk = ~clk;

    mux3 #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .sel(sel),
        .data_in1(a32), .data_in2(b32), .data_in3(c32),
        .en(en), .clr(clr),
        .data_out(out32), .data_out_q(out32_q),
        .sel_err(err32), .sel_err_sticky(sticky32)
    );

    mux3 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .sel(sel),
        .data_in1(a8), .data_in2(b8), .data_in3(c8),
        .en(en), .clr(clr),
        .data_out(out8), .data_out_q(out8_q),
        .sel_err(err8), .sel_err_sticky(sticky8)
    );

    function automatic logic [31:0] pick32(input logic [1:0] s);
        logic [31:0] src [3];
        src[0] = a32; src[1] = b32; src[2] = c32;
        return (s == 2'd3) ? 32'd0 : src[s];
    endfunction

    function automatic logic [7:0] pick8(input logic [1:0] s);
        logic [7:0] src [3];
        src[0] = a8; src[1] = b8; src[2] = c8;
        return (s == 2'd3) ? 8'd0 : src[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        chk({tag, ".out32"}, out32, pick32(sel));
        chk({tag, ".err32"}, {31'd0, err32}, {31'd0, sel == 2'd3});
        chk({tag, ".out8"},  {24'd0, out8}, {24'd0, pick8(sel)});
        chk({tag, ".err8"},  {31'd0, err8}, {31'd0, sel == 2'd3});
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".q32"},     out32_q, m_q32);
        chk({tag, ".q8"},      {24'd0, out8_q}, {24'd0, m_q8});
        chk({tag, ".sticky"},  {31'd0, sticky32}, {31'd0, m_st});
        chk({tag, ".sticky8"}, {31'd0, sticky8}, {31'd0, m_st});
    endtask

    task automatic model_edge();
        if (rst) begin
            m_q32 = '0; m_q8 = '0; m_st = 1'b0;
        end else begin
            if (en) begin
                m_q32 = pick32(sel);
                m_q8  = pick8(sel);
            end
            if (clr)                m_st = 1'b0;
            else if (sel == 2'd3)   m_st = 1'b1;
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick(input string tag);
        #1 chk_comb(tag);
        @(posedge clk);
        model_edge();
        #1 chk_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1 chk_regs("reset");
        chk_comb("reset");
        @(negedge clk);
        rst = 1'b0;

        // Combinational selection stepping through all codes
        a32 = 32'h1; b32 = 32'h2; c32 = 32'h3;
        a8 = 8'hFF; b8 = 8'hA5; c8 = 8'h5A;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick("step_sel");
        end
        clr = 1'b1; sel = 2'd0; tick("clr_after_step");
        clr = 1'b0;

        // Enabled load, one-cycle latency
        en = 1'b1; sel = 2'd0; tick("load_in1");
        sel = 2'd1;            tick("load_in2");
        chk("q_is_2", out32_q, 32'h2);

        // Hold with en=0 while combinational output moves
        en = 1'b0; sel = 2'd2; tick("hold");
        chk("hold_q2", out32_q, 32'h2);
        chk("comb_3", out32, 32'h3);
        en = 1'b1; tick("reload");
        chk("q_is_3", out32_q, 32'h3);

        // Sticky error set, hold, clear, clr priority
        en = 1'b0; sel = 2'd3; tick("err_set");
        chk("sticky_set", {31'd0, sticky32}, 32'd1);
        sel = 2'd0; tick("err_hold1");
        tick("err_hold2");
        clr = 1'b1; tick("err_clr");
        chk("sticky_clr", {31'd0, sticky32}, 32'd0);
        sel = 2'd3; tick("clr_prio");
        chk("clr_prio_val", {31'd0, sticky32}, 32'd0);
        clr = 1'b0; tick("err_reset_up");
        en = 1'b1; sel = 2'd2; tick("q_back_3");

        // Async reset between edges
        #2 rst = 1'b1;
        #1;
        chk("async_q", out32_q, 32'd0);
        chk("async_q8", {24'd0, out8_q}, 32'd0);
        chk("async_sticky", {31'd0, sticky32}, 32'd0);
        chk("async_comb", out32, 32'h3);
        m_q32 = '0; m_q8 = '0; m_st = 1'b0;
        @(negedge clk);
        en = 1'b1; clr = 1'b0; sel = 2'd3; tick("in_reset");
        rst = 1'b0; sel = 2'd1; tick("after_reset");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            sel = 2'($urandom_range(0, 3));
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            a32 = $urandom; b32 = $urandom; c32 = $urandom;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
